// File: rtl/branch_hazard_ctrl_if.sv
// D-stage hazard bus: decoded operand/destination info in, stall and comparator forward selects out.
interface branch_hazard_ctrl_if #(
  parameter int unsigned TNEW_W = 2
);
  logic              d_valid;
  logic [4:0]        d_rs;
  logic [4:0]        d_rt;
  logic              d_use_rs;
  logic              d_use_rt;
  logic [TNEW_W-1:0] d_tuse_rs;
  logic [TNEW_W-1:0] d_tuse_rt;
  logic [4:0]        d_waddr;
  logic [TNEW_W-1:0] d_tnew;
  logic              stall;
  logic [1:0]        fwd_rs;
  logic [1:0]        fwd_rt;

  modport master (
    output d_valid, d_rs, d_rt, d_use_rs, d_use_rt,
           d_tuse_rs, d_tuse_rt, d_waddr, d_tnew,
    input  stall, fwd_rs, fwd_rt
  );

  modport slave (
    input  d_valid, d_rs, d_rt, d_use_rs, d_use_rt,
           d_tuse_rs, d_tuse_rt, d_waddr, d_tnew,
    output stall, fwd_rs, fwd_rt
  );
endinterface

// File: rtl/branch_hazard_ctrl.sv
// Stall/forward scheduler for the D-stage branch comparator using an E/M/W destination scoreboard.
// Optional BRANCH_HAZARD_STALL_CNT_EN adds stall_cnt and fwd_cnt event counters.
module branch_hazard_ctrl #(
  parameter int unsigned TNEW_W = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  branch_hazard_ctrl_if.slave  bus
`ifdef BRANCH_HAZARD_STALL_CNT_EN
  ,
  output logic [31:0]          stall_cnt,
  output logic [31:0]          fwd_cnt
`endif
);

  typedef struct packed {
    logic [4:0]        waddr;
    logic [TNEW_W-1:0] tnew;
  } rec_t;

  localparam int unsigned RES_W = 3;

  rec_t       e_q;
  rec_t       m_q;
  logic [4:0] w_waddr_q;  // W results are always available, so only the address is kept

  logic [RES_W-1:0] res_rs_c;
  logic [RES_W-1:0] res_rt_c;
  logic             stall_c;

  // Per-operand resolution: {stall, fwd[1:0]}; the nearest matching stage decides.
  function automatic logic [RES_W-1:0] resolve(
    input logic              req,
    input logic [4:0]        src,
    input logic [TNEW_W-1:0] tuse,
    input rec_t              e,
    input rec_t              m,
    input logic [4:0]        w
  );
    logic             ok;
    logic [RES_W-1:0] r;
    ok = req && (src != 5'd0);
    r  = '0;
    if (ok && (src == e.waddr)) begin
      r[2]   = (e.tnew > tuse);
      r[1:0] = (e.tnew == '0) ? 2'b01 : 2'b00;
    end else if (ok && (src == m.waddr)) begin
      r[2]   = (m.tnew > tuse);
      r[1:0] = (m.tnew == '0) ? 2'b10 : 2'b00;
    end else if (ok && (src == w)) begin
      r[1:0] = 2'b11;
    end
    return r;
  endfunction

  always_comb begin
    res_rs_c = resolve(bus.d_valid & bus.d_use_rs, bus.d_rs, bus.d_tuse_rs, e_q, m_q, w_waddr_q);
    res_rt_c = resolve(bus.d_valid & bus.d_use_rt, bus.d_rt, bus.d_tuse_rt, e_q, m_q, w_waddr_q);
    stall_c  = res_rs_c[2] | res_rt_c[2];
  end

  assign bus.stall  = stall_c;
  assign bus.fwd_rs = res_rs_c[1:0];
  assign bus.fwd_rt = res_rt_c[1:0];

  // Scoreboard advance; a stalled or empty D slot enters E as a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_q       <= '0;
      m_q       <= '0;
      w_waddr_q <= '0;
    end else begin
      w_waddr_q <= m_q.waddr;
      m_q.waddr <= e_q.waddr;
      m_q.tnew  <= (e_q.tnew == '0) ? '0 : e_q.tnew - TNEW_W'(1);
      if (stall_c || !bus.d_valid) begin
        e_q <= '0;
      end else begin
        e_q.waddr <= bus.d_waddr;
        e_q.tnew  <= bus.d_tnew;
      end
    end
  end

`ifdef BRANCH_HAZARD_STALL_CNT_EN
  logic fwd_any_c;
  assign fwd_any_c = (res_rs_c[1:0] != 2'b00) || (res_rt_c[1:0] != 2'b00);

  // Free-running event counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if (stall_c)   stall_cnt <= stall_cnt + 32'd1;
      if (fwd_any_c) fwd_cnt   <= fwd_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Bench for branch_hazard_ctrl: directed vector table, corner sequences, and random run against a pipeline model.
module tb_branch_hazard_ctrl;

  localparam int unsigned TNEW_W = 2;

  logic clk;
  logic reset;

  branch_hazard_ctrl_if #(.TNEW_W(TNEW_W)) bus ();

`ifdef BRANCH_HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] fwd_cnt;
`endif

  branch_hazard_ctrl #(.TNEW_W(TNEW_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus)
`ifdef BRANCH_HAZARD_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt),
    .fwd_cnt   (fwd_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    int         tuse_rs;
    int         tuse_rt;
    logic [4:0] waddr;
    int         tnew;
    logic       exp_stall;
    logic [1:0] exp_fwd_rs;
    logic [1:0] exp_fwd_rt;
  } vec_t;

  // Model: instructions in flight, index 0=E 1=M 2=W, tnew as it was on entry to E.
  typedef struct {
    logic [4:0] waddr;
    int         tnew;
  } ent_t;

  ent_t        pipe [3];
  int          m_stall_cnt;
  int          m_fwd_cnt;
  int          checks;
  int          failures;
  vec_t        tbl [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ready_in(input int p);
    int r;
    if (p == 2) return 0;
    r = pipe[p].tnew - p;
    return (r < 0) ? 0 : r;
  endfunction

  // Operand result from the model: nearest in-flight writer of the register decides.
  task automatic model_op(input logic req, input logic [4:0] src, input int tuse,
                          output logic st, output logic [1:0] fwd);
    st  = 1'b0;
    fwd = 2'b00;
    if (req && src != 5'd0) begin
      for (int p = 0; p < 3; p++) begin
        if (pipe[p].waddr == src) begin
          if (p < 2 && ready_in(p) > tuse) st = 1'b1;
          fwd = (ready_in(p) == 0) ? 2'(p + 1) : 2'b00;
          break;
        end
      end
    end
  endtask

  task automatic model_eval(input vec_t v, output logic st, output logic [1:0] fr, output logic [1:0] ft);
    logic s1, s2;
    model_op(v.valid & v.use_rs, v.rs, v.tuse_rs, s1, fr);
    model_op(v.valid & v.use_rt, v.rt, v.tuse_rt, s2, ft);
    st = s1 | s2;
  endtask

  task automatic model_advance(input vec_t v, input logic st, input logic [1:0] fr, input logic [1:0] ft);
    if (v.rst) begin
      for (int p = 0; p < 3; p++) pipe[p] = '{5'd0, 0};
      m_stall_cnt = 0;
      m_fwd_cnt   = 0;
    end else begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = (st || !v.valid) ? '{5'd0, 0} : '{v.waddr, v.tnew};
      if (st) m_stall_cnt++;
      if (fr != 2'b00 || ft != 2'b00) m_fwd_cnt++;
    end
  endtask

  // Drive one D-stage cycle, compare at the falling edge, advance the model at the rising edge.
  task automatic run_cycle(input vec_t v, input logic use_exp, input logic do_chk, input string tag);
    logic st;
    logic [1:0] fr, ft;
    reset         = v.rst;
    bus.d_valid   = v.valid;
    bus.d_rs      = v.rs;
    bus.d_rt      = v.rt;
    bus.d_use_rs  = v.use_rs;
    bus.d_use_rt  = v.use_rt;
    bus.d_tuse_rs = TNEW_W'(v.tuse_rs);
    bus.d_tuse_rt = TNEW_W'(v.tuse_rt);
    bus.d_waddr   = v.waddr;
    bus.d_tnew    = TNEW_W'(v.tnew);
    @(negedge clk);
    model_eval(v, st, fr, ft);
    if (do_chk) begin
      if (use_exp) begin
        chk({tag, " stall"},  32'(bus.stall),  32'(v.exp_stall));
        chk({tag, " fwd_rs"}, 32'(bus.fwd_rs), 32'(v.exp_fwd_rs));
        chk({tag, " fwd_rt"}, 32'(bus.fwd_rt), 32'(v.exp_fwd_rt));
      end else begin
        chk({tag, " stall"},  32'(bus.stall),  32'(st));
        chk({tag, " fwd_rs"}, 32'(bus.fwd_rs), 32'(fr));
        chk({tag, " fwd_rt"}, 32'(bus.fwd_rt), 32'(ft));
`ifdef BRANCH_HAZARD_STALL_CNT_EN
        chk({tag, " stall_cnt"}, stall_cnt, 32'(m_stall_cnt));
        chk({tag, " fwd_cnt"},   fwd_cnt,   32'(m_fwd_cnt));
`endif
      end
    end
    @(posedge clk);
    model_advance(v, st, fr, ft);
    #1;
  endtask

  task automatic row(input logic rst, input logic valid, input int rs, input int rt,
                     input logic urs, input logic urt, input int trs, input int trt,
                     input int wa, input int tn, input logic es, input int efr, input int eft);
    vec_t v;
    v = '{rst, valid, 5'(rs), 5'(rt), urs, urt, trs, trt, 5'(wa), tn, es, 2'(efr), 2'(eft)};
    tbl.push_back(v);
  endtask

  function automatic vec_t mk(input logic rst, input logic valid, input int rs, input int rt,
                              input logic urs, input logic urt, input int wa, input int tn);
    vec_t v;
    v = '{rst, valid, 5'(rs), 5'(rt), urs, urt, 0, 0, 5'(wa), tn, 1'b0, 2'b00, 2'b00};
    return v;
  endfunction

  initial begin
    vec_t v;
    checks   = 0;
    failures = 0;
    m_stall_cnt = 0;
    m_fwd_cnt   = 0;
    for (int p = 0; p < 3; p++) pipe[p] = '{5'd0, 0};

    // rst valid rs rt urs urt trs trt waddr tnew | stall fwd_rs fwd_rt
    row(0,0, 0,0, 0,0, 0,0, 0,0,  0,0,0);
    row(0,0, 0,0, 0,0, 0,0, 0,0,  0,0,0);
    row(0,0, 0,0, 0,0, 0,0, 0,0,  0,0,0);
    row(0,1, 0,0, 0,0, 0,0, 8,1,  0,0,0);   // addu $8
    row(0,1, 8,9, 1,1, 0,0, 0,0,  1,0,0);   // beq $8,$9: producer in E
    row(0,1, 8,9, 1,1, 0,0, 0,0,  0,2,0);   // released, forward from M
    row(0,0, 0,0, 0,0, 0,0, 0,0,  0,0,0);
    row(0,1, 0,0, 0,0, 0,0, 5,2,  0,0,0);   // lw $5
    row(0,1, 5,0, 1,1, 0,0, 0,0,  1,0,0);   // bne $5,$0
    row(0,1, 5,0, 1,1, 0,0, 0,0,  1,0,0);
    row(0,1, 5,0, 1,1, 0,0, 0,0,  0,3,0);
    row(0,0, 0,0, 0,0, 0,0, 0,0,  0,0,0);
    row(0,1, 0,0, 0,0, 0,0, 3,0,  0,0,0);   // lui $3
    row(0,1, 3,3, 1,1, 0,0, 0,0,  0,1,1);   // beq $3,$3
    row(0,1, 0,0, 0,0, 0,0, 7,1,  0,0,0);   // addu $7
    row(0,1, 0,0, 0,0, 0,0, 0,0,  0,0,0);
    row(0,1, 0,0, 0,0, 0,0, 0,0,  0,0,0);
    row(0,1, 7,0, 1,0, 0,0, 0,0,  0,3,0);   // bgez $7 from W
    row(0,1, 0,0, 0,0, 0,0, 7,1,  0,0,0);
    row(0,1, 0,0, 0,0, 0,0, 0,0,  0,0,0);
    row(0,1, 0,0, 0,0, 0,0, 7,1,  0,0,0);
    row(0,1, 7,0, 1,0, 0,0, 0,0,  1,0,0);   // E copy masks W copy
    row(0,1, 7,0, 1,0, 0,0, 0,0,  0,2,0);
    row(0,1, 0,0, 0,0, 0,0, 4,2,  0,0,0);   // lw $4
    row(0,1, 4,0, 1,0, 1,0, 6,1,  1,0,0);   // reader with tuse 1
    row(0,1, 4,0, 1,0, 1,0, 6,1,  0,0,0);   // M not ready yet but tuse allows it
    row(0,1, 0,0, 0,0, 0,0, 5,2,  0,0,0);   // lw $5
    row(0,1, 5,0, 1,1, 0,0, 0,0,  1,0,0);
    row(1,1, 5,0, 1,1, 0,0, 0,0,  1,0,0);   // reset during stall
    row(0,1, 5,0, 1,1, 0,0, 0,0,  0,0,0);   // stall gone after reset

    reset = 1'b1;
    for (int i = 0; i < 2; i++) run_cycle(mk(1, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0, "init");

    for (int i = 0; i < tbl.size(); i++)
      run_cycle(tbl[i], 1'b1, 1'b1, $sformatf("vec%0d", i));

`ifdef BRANCH_HAZARD_STALL_CNT_EN
    run_cycle(mk(1, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0, "cnt_rst");
    chk("cnt_after_reset stall_cnt", stall_cnt, 32'd0);
    chk("cnt_after_reset fwd_cnt",   fwd_cnt,   32'd0);
    run_cycle(mk(0, 1, 0, 0, 0, 0, 5, 2), 1'b0, 1'b1, "cnt_lw");
    for (int i = 0; i < 3; i++) run_cycle(mk(0, 1, 5, 0, 1, 1, 0, 0), 1'b0, 1'b1, "cnt_bne");
    chk("cnt_lw_bne stall_cnt", stall_cnt, 32'd2);
    chk("cnt_lw_bne fwd_cnt",   fwd_cnt,   32'd1);
`endif

    // Random traffic over a small register set so hazards are frequent.
    for (int i = 0; i < 400; i++) begin
      v.rst       = ($urandom_range(0, 39) == 0);
      v.valid     = ($urandom_range(0, 4) != 0);
      v.rs        = 5'($urandom_range(0, 3));
      v.rt        = 5'($urandom_range(0, 3));
      v.use_rs    = 1'($urandom_range(0, 1));
      v.use_rt    = 1'($urandom_range(0, 1));
      v.tuse_rs   = int'($urandom_range(0, 3));
      v.tuse_rt   = int'($urandom_range(0, 3));
      v.waddr     = 5'($urandom_range(0, 3));
      v.tnew      = int'($urandom_range(0, 3));
      v.exp_stall = 1'b0;
      v.exp_fwd_rs = 2'b00;
      v.exp_fwd_rt = 2'b00;
      run_cycle(v, 1'b0, 1'b1, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
